// File: rtl/sdram_arbit.sv
// sdram_arbit: shares the SDRAM pins between the init, auto-refresh, write
// and read engines.
//   - Until init_end rises the init engine drives the pins directly.
//   - Afterwards one engine at a time is granted (refresh > write > read);
//     an ARB state driving NOP always sits between two grants.
//   - Optional macro ARB_RR_EN: write/read alternate when both request
//     (refresh stays on top). Undefined: write always beats read.
// Ports:
//   arb_clk, arb_rst             clock, async active-high reset
//   init_*                       init engine bus + init_end level
//   aref_*, wr_*, rd_*           engine req level, end pulse, cmd/bank/addr
//   wr_sdram_en/wr_sdram_data    write data path
//   aref_en, wr_en, rd_en        grants (decoded from state register)
//   sdram_*                      device pins; dq_oe controls external pad
module sdram_arbit #(
  parameter int ADDR_W = 13,
  parameter int BANK_W = 2,
  parameter int DATA_W = 16
) (
  input  logic              arb_clk,
  input  logic              arb_rst,
  input  logic              init_end,
  input  logic [3:0]        init_cmd,
  input  logic [BANK_W-1:0] init_bank,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic              aref_req,
  input  logic              aref_end,
  input  logic [3:0]        aref_cmd,
  input  logic [BANK_W-1:0] aref_bank,
  input  logic [ADDR_W-1:0] aref_addr,
  input  logic              wr_req,
  input  logic              wr_end,
  input  logic [3:0]        wr_sdram_cmd,
  input  logic [BANK_W-1:0] wr_sdram_bank,
  input  logic [ADDR_W-1:0] wr_sdram_addr,
  input  logic              wr_sdram_en,
  input  logic [DATA_W-1:0] wr_sdram_data,
  input  logic              rd_req,
  input  logic              rd_end,
  input  logic [3:0]        rd_sdram_cmd,
  input  logic [BANK_W-1:0] rd_sdram_bank,
  input  logic [ADDR_W-1:0] rd_sdram_addr,
  output logic              aref_en,
  output logic              wr_en,
  output logic              rd_en,
  output logic              sdram_cke,
  output logic              sdram_cs_n,
  output logic              sdram_ras_n,
  output logic              sdram_cas_n,
  output logic              sdram_we_n,
  output logic [BANK_W-1:0] sdram_bank,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic [DATA_W-1:0] sdram_dq_out,
  output logic              sdram_dq_oe
);

  typedef enum logic [2:0] {INIT, ARB, AREF, WRITE, READ} state_t;

  localparam logic [3:0] CMD_NOP = 4'b0111;

  state_t     state;
  logic       wr_win;
  logic [3:0] cmd;

`ifdef ARB_RR_EN
  // 1 = write served last; reset value 0 means read was last, so write
  // gets the first contested slot.
  logic last_wr;
  assign wr_win = wr_req & (~rd_req | ~last_wr);
`else
  assign wr_win = wr_req;
`endif

  always_ff @(posedge arb_clk or posedge arb_rst) begin
    if (arb_rst) begin
      state     <= INIT;
      sdram_cke <= 1'b0;
`ifdef ARB_RR_EN
      last_wr   <= 1'b0;
`endif
    end else begin
      sdram_cke <= 1'b1;
      case (state)
        INIT:  if (init_end) state <= ARB;
        ARB: begin
          // losing init_end outranks every pending request
          if (!init_end)     state <= INIT;
          else if (aref_req) state <= AREF;
          else if (wr_win) begin
            state <= WRITE;
`ifdef ARB_RR_EN
            last_wr <= 1'b1;
`endif
          end else if (rd_req) begin
            state <= READ;
`ifdef ARB_RR_EN
            last_wr <= 1'b0;
`endif
          end
        end
        AREF:  if (aref_end) state <= ARB;
        WRITE: if (wr_end)   state <= ARB;
        READ:  if (rd_end)   state <= ARB;
        default: state <= INIT;
      endcase
    end
  end

  assign aref_en = (state == AREF);
  assign wr_en   = (state == WRITE);
  assign rd_en   = (state == READ);

  always_comb begin
    cmd        = CMD_NOP;
    sdram_bank = '0;
    sdram_addr = '0;
    case (state)
      INIT:  begin cmd = init_cmd;     sdram_bank = init_bank;     sdram_addr = init_addr;     end
      AREF:  begin cmd = aref_cmd;     sdram_bank = aref_bank;     sdram_addr = aref_addr;     end
      WRITE: begin cmd = wr_sdram_cmd; sdram_bank = wr_sdram_bank; sdram_addr = wr_sdram_addr; end
      READ:  begin cmd = rd_sdram_cmd; sdram_bank = rd_sdram_bank; sdram_addr = rd_sdram_addr; end
      default: ;
    endcase
  end

  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd;

  assign sdram_dq_out = wr_sdram_data;
  assign sdram_dq_oe  = wr_sdram_en & (state == WRITE);

endmodule

// File: tb/tb_sdram_arbit.sv
module tb_sdram_arbit;
  localparam int ADDR_W = 13, BANK_W = 2, DATA_W = 16;

  logic              arb_clk = 1'b0, arb_rst = 1'b1;
  logic              init_end = 1'b0;
  logic [3:0]        init_cmd = 4'b0001;
  logic [BANK_W-1:0] init_bank = 2'd3;
  logic [ADDR_W-1:0] init_addr = 13'h0400;
  logic              aref_req = 0, aref_end = 0;
  logic [3:0]        aref_cmd = 4'b0001;
  logic [BANK_W-1:0] aref_bank = 2'd0;
  logic [ADDR_W-1:0] aref_addr = 13'h0011;
  logic              wr_req = 0, wr_end = 0;
  logic [3:0]        wr_sdram_cmd = 4'b0100;
  logic [BANK_W-1:0] wr_sdram_bank = 2'd1;
  logic [ADDR_W-1:0] wr_sdram_addr = 13'h0055;
  logic              wr_sdram_en = 0;
  logic [DATA_W-1:0] wr_sdram_data = 16'hA5A5;
  logic              rd_req = 0, rd_end = 0;
  logic [3:0]        rd_sdram_cmd = 4'b0101;
  logic [BANK_W-1:0] rd_sdram_bank = 2'd2;
  logic [ADDR_W-1:0] rd_sdram_addr = 13'h1ABC;
  logic              aref_en, wr_en, rd_en, sdram_cke;
  logic              sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
  logic [BANK_W-1:0] sdram_bank;
  logic [ADDR_W-1:0] sdram_addr;
  logic [DATA_W-1:0] sdram_dq_out;
  logic              sdram_dq_oe;

  int n_chk = 0, n_err = 0;

  always #5 arb_clk = ~arb_clk;

  sdram_arbit #(.ADDR_W(ADDR_W), .BANK_W(BANK_W), .DATA_W(DATA_W)) dut (
    .arb_clk(arb_clk), .arb_rst(arb_rst),
    .init_end(init_end), .init_cmd(init_cmd), .init_bank(init_bank), .init_addr(init_addr),
    .aref_req(aref_req), .aref_end(aref_end), .aref_cmd(aref_cmd),
    .aref_bank(aref_bank), .aref_addr(aref_addr),
    .wr_req(wr_req), .wr_end(wr_end), .wr_sdram_cmd(wr_sdram_cmd),
    .wr_sdram_bank(wr_sdram_bank), .wr_sdram_addr(wr_sdram_addr),
    .wr_sdram_en(wr_sdram_en), .wr_sdram_data(wr_sdram_data),
    .rd_req(rd_req), .rd_end(rd_end), .rd_sdram_cmd(rd_sdram_cmd),
    .rd_sdram_bank(rd_sdram_bank), .rd_sdram_addr(rd_sdram_addr),
    .aref_en(aref_en), .wr_en(wr_en), .rd_en(rd_en), .sdram_cke(sdram_cke),
    .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n),
    .sdram_cas_n(sdram_cas_n), .sdram_we_n(sdram_we_n),
    .sdram_bank(sdram_bank), .sdram_addr(sdram_addr),
    .sdram_dq_out(sdram_dq_out), .sdram_dq_oe(sdram_dq_oe)
  );

  wire [3:0] cmd = {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n};
  wire [2:0] gnt = {aref_en, wr_en, rd_en};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // advance one clock; outputs are then sampled 1 time unit after the edge
  task automatic tick;
    @(posedge arb_clk);
    #1;
  endtask

  task automatic chk_nop(input string tag);
    chk({tag, "_gnt"}, {29'd0, gnt}, 32'd0);
    chk({tag, "_cmd"}, {28'd0, cmd}, 32'h7);
    chk({tag, "_addr"}, {19'd0, sdram_addr}, 32'd0);
  endtask

  logic [2:0] burst_exp [6];

  initial begin
    // 1: reset and init pass-through
    #2;
    chk("rst_cke", {31'd0, sdram_cke}, 32'd0);
    chk("rst_gnt", {29'd0, gnt}, 32'd0);
    chk("rst_oe", {31'd0, sdram_dq_oe}, 32'd0);
    chk("rst_cmd", {28'd0, cmd}, 32'h1);
    tick; arb_rst = 1'b0;
    tick;
    chk("cke_up", {31'd0, sdram_cke}, 32'd1);
    chk("init_cmd", {28'd0, cmd}, 32'h1);
    chk("init_addr", {19'd0, sdram_addr}, 32'h0400);
    chk("init_bank", {30'd0, sdram_bank}, 32'd3);
    init_end = 1'b1;
    tick;
    chk_nop("arb0");

    // 2: write grant, pin mux, dq_oe, foreign end ignored
    wr_req = 1'b1;
    #1 chk("wr_lat0", {31'd0, wr_en}, 32'd0);
    tick;
    chk("wr_gnt", {29'd0, gnt}, 32'b010);
    chk("wr_cmd", {28'd0, cmd}, 32'h4);
    chk("wr_addr", {19'd0, sdram_addr}, 32'h0055);
    chk("wr_bank", {30'd0, sdram_bank}, 32'd1);
    chk("wr_oe0", {31'd0, sdram_dq_oe}, 32'd0);
    wr_sdram_en = 1'b1;
    #1;
    chk("wr_oe1", {31'd0, sdram_dq_oe}, 32'd1);
    chk("wr_dq", {16'd0, sdram_dq_out}, 32'hA5A5);
    rd_end = 1'b1; aref_end = 1'b1;
    tick;
    chk("foreign_end", {29'd0, gnt}, 32'b010);
    rd_end = 1'b0; aref_end = 1'b0;
    wr_end = 1'b1; wr_req = 1'b0;
    tick;
    chk_nop("wr_done");
    chk("wr_done_oe", {31'd0, sdram_dq_oe}, 32'd0);
    wr_end = 1'b0; wr_sdram_en = 1'b0;

    // read burst: read pin mux
    rd_req = 1'b1;
    tick;
    chk("rd_gnt", {29'd0, gnt}, 32'b001);
    chk("rd_cmd", {28'd0, cmd}, 32'h5);
    chk("rd_addr", {19'd0, sdram_addr}, 32'h1ABC);
    chk("rd_bank", {30'd0, sdram_bank}, 32'd2);
    rd_end = 1'b1; rd_req = 1'b0;
    tick; chk_nop("rd_done"); rd_end = 1'b0;

    // 3: all three at once -> AREF, NOP, WRITE, NOP, READ, NOP
    aref_req = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
    tick;
    chk("t3_aref", {29'd0, gnt}, 32'b100);
    chk("t3_aref_cmd", {28'd0, cmd}, 32'h1);
    chk("t3_aref_addr", {19'd0, sdram_addr}, 32'h0011);
    aref_end = 1'b1; aref_req = 1'b0;
    tick; chk_nop("t3_nop1"); aref_end = 1'b0;
    tick; chk("t3_wr", {29'd0, gnt}, 32'b010);
    wr_end = 1'b1; wr_req = 1'b0;
    tick; chk_nop("t3_nop2"); wr_end = 1'b0;
    tick; chk("t3_rd", {29'd0, gnt}, 32'b001);
    rd_end = 1'b1; rd_req = 1'b0;
    tick; chk_nop("t3_nop3"); rd_end = 1'b0;

    // 5: wr_req and rd_req held across six bursts
`ifdef ARB_RR_EN
    burst_exp = '{3'b010, 3'b001, 3'b010, 3'b001, 3'b010, 3'b001};
`else
    burst_exp = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b010};
`endif
    wr_req = 1'b1; rd_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick;
      chk($sformatf("t5_burst%0d", i), {29'd0, gnt}, {29'd0, burst_exp[i]});
      wr_end = wr_en; rd_end = rd_en;
      if (i == 5) begin wr_req = 1'b0; rd_req = 1'b0; end
      tick;
      chk_nop($sformatf("t5_nop%0d", i));
      wr_end = 1'b0; rd_end = 1'b0;
    end

    // 4: refresh raised mid-write waits, then beats the held write
    wr_req = 1'b1;
    tick; chk("t4_wr", {29'd0, gnt}, 32'b010);
    aref_req = 1'b1;
    tick; chk("t4_nopreempt", {29'd0, gnt}, 32'b010);
    wr_end = 1'b1;
    tick; chk_nop("t4_nop1"); wr_end = 1'b0;
    tick; chk("t4_aref", {29'd0, gnt}, 32'b100);
    aref_end = 1'b1; aref_req = 1'b0;
    tick; chk_nop("t4_nop2"); aref_end = 1'b0;
    tick; chk("t4_wr2", {29'd0, gnt}, 32'b010);
    wr_end = 1'b1; wr_req = 1'b0;
    tick; chk_nop("t4_nop3"); wr_end = 1'b0;

    // init_end drop in ARB outranks a pending request
    init_end = 1'b0; wr_req = 1'b1;
    tick;
    chk("drop_gnt", {29'd0, gnt}, 32'd0);
    chk("drop_cmd", {28'd0, cmd}, 32'h1);
    wr_req = 1'b0; init_end = 1'b1;
    tick; chk_nop("drop_arb");

    // 6: reset mid-read, then re-init
    rd_req = 1'b1; wr_sdram_en = 1'b1;
    tick; chk("t6_rd", {29'd0, gnt}, 32'b001);
    #2 arb_rst = 1'b1; init_end = 1'b0; rd_req = 1'b0;
    #1;
    chk("t6_gnt", {29'd0, gnt}, 32'd0);
    chk("t6_oe", {31'd0, sdram_dq_oe}, 32'd0);
    chk("t6_cmd", {28'd0, cmd}, 32'h1);
    chk("t6_cke", {31'd0, sdram_cke}, 32'd0);
    tick; arb_rst = 1'b0; wr_sdram_en = 1'b0;
    tick;
    chk("t6_init", {28'd0, cmd}, 32'h1);
    chk("t6_cke1", {31'd0, sdram_cke}, 32'd1);
    init_end = 1'b1;
    tick; chk_nop("t6_arb");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1);
  end
endmodule
